// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants.
// Register file geometry and the hard-wired zero register index.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select and commit qualifier.
// Picks load data or ALU result; flags a real register write.
module wb_mux
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              rst,
   input  logic              WB_EN,
   input  logic              MEM_R_EN,
   input  logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] ALUresult,
   input  logic [ADDR_W-1:0] Dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid
);

   logic dest_nz;

   assign dest_nz = (Dest != ADDR_W'(REG_ZERO));

   // Source select; the enable is checked separately so an unknown
   // select with WB_EN low can never reach the register file.
   always_comb begin
      wb_data  = ALUresult;
      wb_valid = 1'b0;
      if (MEM_R_EN) begin
         wb_data = read_data;
      end
      if (!rst && WB_EN && dest_nz) begin
         wb_valid = 1'b1;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB write-back stage with 32x32 register file and retire counter.
// Optional same-cycle WB->ID bypass when WB_BYPASS_EN is defined.
module wb_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_EN,
   input  logic              MEM_R_EN,
   input  logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] ALUresult,
   input  logic [ADDR_W-1:0] Dest,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid,
   output logic [CNT_W-1:0]  wb_count
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rs_rd;
   logic [DATA_W-1:0] rt_rd;

   wb_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_mux (
      .rst      (rst),
      .WB_EN    (WB_EN),
      .MEM_R_EN (MEM_R_EN),
      .read_data(read_data),
      .ALUresult(ALUresult),
      .Dest     (Dest),
      .wb_data  (wb_data),
      .wb_valid (wb_valid)
   );

   // Commit storage; wb_valid already excludes reset and register 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_valid) begin
         regs[Dest] <= wb_data;
      end
   end

   // Retired write-back counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count <= '0;
      end else if (wb_valid) begin
         wb_count <= wb_count + CNT_W'(1);
      end
   end

   // Stored-value read ports; index 0 is hard-wired to zero.
   always_comb begin
      rs_rd = '0;
      rt_rd = '0;
      if (rs_addr != ADDR_W'(REG_ZERO)) begin
         rs_rd = regs[rs_addr];
      end
      if (rt_addr != ADDR_W'(REG_ZERO)) begin
         rt_rd = regs[rt_addr];
      end
   end

`ifdef WB_BYPASS_EN
   // Forward the value being committed this cycle to a matching reader.
   always_comb begin
      rs_data = rs_rd;
      rt_data = rt_rd;
      if (wb_valid && rs_addr == Dest) begin
         rs_data = wb_data;
      end
      if (wb_valid && rt_addr == Dest) begin
         rt_data = wb_data;
      end
   end
`else
   // No bypass: a new value shows up the cycle after commit.
   always_comb begin
      rs_data = rs_rd;
      rt_data = rt_rd;
   end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile, main instance plus a CNT_W=4 instance.
// Expectations follow the WB_BYPASS_EN setting of the build.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_EN;
   logic        MEM_R_EN;
   logic [31:0] read_data;
   logic [31:0] ALUresult;
   logic [4:0]  Dest;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data;
   logic        wb_valid;
   logic [31:0] wb_count;

   logic [31:0] s_rs_data;
   logic [31:0] s_rt_data;
   logic [31:0] s_wb_data;
   logic        s_wb_valid;
   logic [3:0]  s_wb_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk      (clk),
      .rst      (rst),
      .WB_EN    (WB_EN),
      .MEM_R_EN (MEM_R_EN),
      .read_data(read_data),
      .ALUresult(ALUresult),
      .Dest     (Dest),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .wb_data  (wb_data),
      .wb_valid (wb_valid),
      .wb_count (wb_count)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .WB_EN    (WB_EN),
      .MEM_R_EN (MEM_R_EN),
      .read_data(read_data),
      .ALUresult(ALUresult),
      .Dest     (Dest),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (s_rs_data),
      .rt_data  (s_rt_data),
      .wb_data  (s_wb_data),
      .wb_valid (s_wb_valid),
      .wb_count (s_wb_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst       = 1'b0;
      WB_EN     = 1'b0;
      MEM_R_EN  = 1'b0;
      read_data = '0;
      ALUresult = '0;
      Dest      = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_vec++;
      if (wb_count !== 32'd0) begin
         n_err++;
         $display("FAIL reset_count got=%0d exp=0", wb_count);
      end
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         #1;
         n_vec++;
         if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reg%0d rs=%h rt=%h exp=0",
                     i, rs_data, rt_data);
         end
      end
   endtask

   task automatic test_alu_write();
      WB_EN     = 1'b1;
      MEM_R_EN  = 1'b0;
      ALUresult = 32'h0000_1234;
      read_data = 32'h5555_5555;
      Dest      = 5'd5;
      #1;
      n_vec++;
      if (wb_data !== 32'h1234 || wb_valid !== 1'b1) begin
         n_err++;
         $display("FAIL alu_sel data=%h valid=%b exp=1234/1",
                  wb_data, wb_valid);
      end
      tick();
      idle();
      rs_addr = 5'd5;
      #1;
      n_vec++;
      if (rs_data !== 32'h1234 || wb_count !== 32'd1) begin
         n_err++;
         $display("FAIL alu_write rs=%h cnt=%0d exp=1234/1",
                  rs_data, wb_count);
      end
   endtask

   task automatic test_load_write();
      WB_EN     = 1'b1;
      MEM_R_EN  = 1'b1;
      read_data = 32'hDEAD_BEEF;
      ALUresult = 32'h1;
      Dest      = 5'd9;
      #1;
      n_vec++;
      if (wb_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL load_sel got=%h exp=deadbeef", wb_data);
      end
      tick();
      idle();
      rt_addr = 5'd9;
      #1;
      n_vec++;
      if (rt_data !== 32'hDEAD_BEEF || wb_count !== 32'd2) begin
         n_err++;
         $display("FAIL load_write rt=%h cnt=%0d exp=deadbeef/2",
                  rt_data, wb_count);
      end
   endtask

   task automatic test_zero_dest();
      WB_EN     = 1'b1;
      ALUresult = 32'hFFFF_FFFF;
      Dest      = 5'd0;
      #1;
      n_vec++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL zero_valid got=%b exp=0", wb_valid);
      end
      tick();
      idle();
      rs_addr = 5'd0;
      #1;
      n_vec++;
      if (rs_data !== 32'd0 || wb_count !== 32'd2) begin
         n_err++;
         $display("FAIL zero_dest rs=%h cnt=%0d exp=0/2",
                  rs_data, wb_count);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_now;
      WB_EN     = 1'b1;
      ALUresult = 32'h11;
      Dest      = 5'd7;
      tick();
      ALUresult = 32'hA5;
      rs_addr   = 5'd7;
      rt_addr   = 5'd7;
`ifdef WB_BYPASS_EN
      exp_now = 32'hA5;
`else
      exp_now = 32'h11;
`endif
      #1;
      n_vec++;
      if (rs_data !== exp_now || rt_data !== exp_now) begin
         n_err++;
         $display("FAIL same_cycle rs=%h rt=%h exp=%h",
                  rs_data, rt_data, exp_now);
      end
      tick();
      idle();
      #1;
      n_vec++;
      if (rs_data !== 32'hA5 || rt_data !== 32'hA5 ||
          wb_count !== 32'd4) begin
         n_err++;
         $display("FAIL next_cycle rs=%h rt=%h cnt=%0d exp=a5/a5/4",
                  rs_data, rt_data, wb_count);
      end
   endtask

   task automatic test_x_select();
      WB_EN     = 1'b0;
      MEM_R_EN  = 1'bx;
      ALUresult = 32'hBAD0_BAD0;
      read_data = 32'hBAD1_BAD1;
      Dest      = 5'd5;
      tick();
      idle();
      rs_addr = 5'd5;
      #1;
      n_vec++;
      if (rs_data !== 32'h1234 || wb_count !== 32'd4) begin
         n_err++;
         $display("FAIL x_select rs=%h cnt=%0d exp=1234/4",
                  rs_data, wb_count);
      end
   endtask

   task automatic test_reset_collision();
      rst       = 1'b1;
      WB_EN     = 1'b1;
      ALUresult = 32'h77;
      Dest      = 5'd3;
      #1;
      n_vec++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_valid got=%b exp=0", wb_valid);
      end
      tick();
      idle();
      rs_addr = 5'd3;
      rt_addr = 5'd9;
      #1;
      n_vec++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0 ||
          wb_count !== 32'd0 || s_wb_count !== 4'd0) begin
         n_err++;
         $display("FAIL rst_collide rs=%h rt=%h cnt=%0d/%0d exp=0",
                  rs_data, rt_data, wb_count, s_wb_count);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 17; i++) begin
         WB_EN     = 1'b1;
         MEM_R_EN  = 1'b0;
         ALUresult = 32'(100 + 3 * i);
         Dest      = 5'(i % 31 + 1);
         tick();
         if (i == 0) begin
            n_vec++;
            if (wb_count !== 32'd1) begin
               n_err++;
               $display("FAIL first_after_rst got=%0d exp=1",
                        wb_count);
            end
         end
      end
      idle();
      rs_addr = 5'd17;
      rt_addr = 5'd1;
      #1;
      n_vec++;
      if (wb_count !== 32'd17 || s_wb_count !== 4'd1) begin
         n_err++;
         $display("FAIL wrap cnt=%0d cnt4=%0d exp=17/1",
                  wb_count, s_wb_count);
      end
      n_vec++;
      if (rs_data !== 32'd148 || rt_data !== 32'd100) begin
         n_err++;
         $display("FAIL wrap_regs rs=%0d rt=%0d exp=148/100",
                  rs_data, rt_data);
      end
   endtask

   initial begin
      idle();
      rs_addr = '0;
      rt_addr = '0;
      test_reset();
      test_alu_write();
      test_load_write();
      test_zero_dest();
      test_bypass();
      test_x_select();
      test_reset_collision();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
